fir_output_serializer: RTL and testbench

//   Sits directly downstream of the FIR core. Buffers parallel FIR output words (fir_dout) in a

---
 rtl/fir_output_serializer_if.sv | 36 +++
 rtl/fir_output_serializer.sv | 116 +++++++++++
 tb/tb_fir_output_serializer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/fir_output_serializer_if.sv
// ============================================================================
// Module   : fir_output_serializer_if
// Purpose  : Parallel-in / serial-out handshake bundle of the FIR output serializer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface fir_output_serializer_if #(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 4
);
    localparam int FILL_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0] i_din;
    logic                  i_din_valid;
    logic                  o_ready;
    logic                  o_dout;
    logic                  o_dout_valid;
    logic                  i_ready;
    logic [FILL_W-1:0]     o_fill_level;
    logic                  o_overflow;

    // Serializer side
    modport master (
        input  i_din, i_din_valid, i_ready,
        output o_ready, o_dout, o_dout_valid, o_fill_level, o_overflow
    );

    // FIR producer / serial consumer side
    modport slave (
        output i_din, i_din_valid, i_ready,
        input  o_ready, o_dout, o_dout_valid, o_fill_level, o_overflow
    );
endinterface

`default_nettype wire

// File: rtl/fir_output_serializer.sv
// ============================================================================
// Module   : fir_output_serializer
// Purpose  : FIFO-buffered parallel-to-serial converter (LSB first) for FIR output words.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fir_output_serializer #(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    fir_output_serializer_if.master bus
);
    localparam int c_addr_w = $clog2(FIFO_DEPTH);
    localparam int c_fill_w = c_addr_w + 1;
    localparam int c_cnt_w  = $clog2(DATA_WIDTH);
    localparam logic [c_fill_w-1:0] c_full = c_fill_w'(FIFO_DEPTH);
    localparam logic [c_cnt_w-1:0]  c_last = c_cnt_w'(DATA_WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_fill_w-1:0]   r_wr_ptr;
    logic [c_fill_w-1:0]   r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic [c_cnt_w-1:0]    r_bit_cnt;
    logic                  r_overflow;

    logic [c_fill_w-1:0]   w_fill;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_xfer;
    logic                  w_last;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_head;

    // Pointers carry one extra wrap bit so full and empty stay distinguishable.
    assign w_fill  = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_fill == c_full);
    assign w_empty = (w_fill == '0);
    assign w_push  = i_en && bus.i_din_valid && !w_full;
    assign w_xfer  = i_en && bus.i_ready && (r_state == S_SHIFT);
    assign w_last  = (r_bit_cnt == c_last);
    assign w_pop   = !w_empty && ((i_en && (r_state == S_IDLE)) || (w_xfer && w_last));
    assign w_head  = r_mem[r_rd_ptr[c_addr_w-1:0]];

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_addr_w-1:0]] <= bus.i_din;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_shreg    <= '0;
            r_bit_cnt  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_fill_w'(1);
            end
            // Fullness is judged before any same-cycle pop, so such a word is still dropped.
            if (i_en && bus.i_din_valid && w_full) begin
                r_overflow <= 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_fill_w'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_shreg   <= w_head;
                        r_bit_cnt <= '0;
                        r_state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (w_xfer) begin
                        if (!w_last) begin
                            r_shreg   <= r_shreg >> 1;
                            r_bit_cnt <= r_bit_cnt + c_cnt_w'(1);
                        end else if (w_pop) begin
                            // Back-to-back words: reload without an idle gap.
                            r_shreg   <= w_head;
                            r_bit_cnt <= '0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_dout_valid = (r_state == S_SHIFT);
    assign bus.o_dout       = (r_state == S_SHIFT) && r_shreg[0];
    assign bus.o_ready      = !w_full;
    assign bus.o_fill_level = w_fill;
    assign bus.o_overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_fir_output_serializer.sv
// ============================================================================
// Module   : tb_fir_output_serializer
// Purpose  : Directed, table-driven self-checking bench for fir_output_serializer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fir_output_serializer;
    logic tb_clk = 1'b0;
    logic rst    = 1'b1;
    logic en     = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 tb_clk = ~tb_clk;

    fir_output_serializer_if #(.DATA_WIDTH(24), .FIFO_DEPTH(4)) bus ();

    fir_output_serializer #(.DATA_WIDTH(24), .FIFO_DEPTH(4)) dut (
        .i_clk (tb_clk),
        .i_rst (rst),
        .i_en  (en),
        .bus   (bus)
    );

    typedef struct {
        logic [23:0] word;
        bit          toggle;
        int          exp_valid;
    } vec_t;

    vec_t        vecs [4];
    logic [23:0] tx_q [$];
    logic [23:0] rx_q [$];
    int          valid_cycles, gap_cycles, stable_err, first_valid, ready_low;

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Feeds tx_q one word per cycle while reassembling serial words into rx_q.
    task automatic collect(input int nwords, input bit toggle, input int budget);
        int          cyc     = 0;
        int          nb      = 0;
        logic [23:0] acc     = '0;
        logic        held    = 1'b0;
        bit          stalled = 1'b0;
        bit          started = 1'b0;
        rx_q.delete();
        valid_cycles = 0; gap_cycles = 0; stable_err = 0; first_valid = -1; ready_low = 0;
        while (rx_q.size() < nwords && cyc < budget) begin
            bus.i_ready = toggle ? (cyc % 2 == 1) : 1'b1;
            if (tx_q.size() > 0) begin
                bus.i_din_valid = 1'b1;
                bus.i_din       = tx_q.pop_front();
            end else begin
                bus.i_din_valid = 1'b0;
            end
            if (!bus.o_ready) ready_low++;
            if (bus.o_dout_valid) begin
                if (!started) first_valid = cyc;
                started = 1'b1;
                valid_cycles++;
                if (stalled && bus.o_dout !== held) stable_err++;
                if (bus.i_ready) begin
                    acc[nb] = bus.o_dout;
                    nb++;
                    stalled = 1'b0;
                    if (nb == 24) begin
                        rx_q.push_back(acc);
                        nb = 0;
                    end
                end else begin
                    stalled = 1'b1;
                    held    = bus.o_dout;
                end
            end else if (started) begin
                gap_cycles++;
            end
            tick();
            cyc++;
        end
        bus.i_din_valid = 1'b0;
        bus.i_ready     = 1'b1;
        chk("collect_word_count", rx_q.size(), nwords);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [23:0] acc;
        logic        held;
        int          vcount;

        vecs[0] = '{24'h800001, 1'b0, 24};
        vecs[1] = '{24'hA5A5A5, 1'b1, 48};
        vecs[2] = '{24'h000000, 1'b0, 24};
        vecs[3] = '{24'hFFFFFF, 1'b1, 48};

        bus.i_din = '0; bus.i_din_valid = 1'b0; bus.i_ready = 1'b1;
        tick();
        do_reset();
        chk("rst_valid",    32'(bus.o_dout_valid), 0);
        chk("rst_dout",     32'(bus.o_dout),       0);
        chk("rst_ready",    32'(bus.o_ready),      1);
        chk("rst_fill",     32'(bus.o_fill_level), 0);
        chk("rst_overflow", 32'(bus.o_overflow),   0);

        // Single words, with and without back-pressure
        for (int i = 0; i < 4; i++) begin
            tx_q.push_back(vecs[i].word);
            collect(1, vecs[i].toggle, 200);
            chk("vec_first_valid", first_valid, 2);
            chk("vec_valid_cycles", valid_cycles, vecs[i].exp_valid);
            chk("vec_stall_stable", stable_err, 0);
            chk("vec_gap", gap_cycles, 0);
            if (rx_q.size() > 0) chk("vec_word", rx_q[0], vecs[i].word);
            chk("vec_end_valid", 32'(bus.o_dout_valid), 0);
            chk("vec_end_dout",  32'(bus.o_dout), 0);
        end

        // Burst of four words on consecutive cycles
        for (int i = 1; i <= 4; i++) tx_q.push_back(24'(i));
        collect(4, 1'b0, 300);
        for (int i = 0; i < 4 && i < rx_q.size(); i++) chk("burst_word", rx_q[i], 24'(i + 1));
        chk("burst_valid_cycles", valid_cycles, 96);
        chk("burst_gap", gap_cycles, 0);
        chk("burst_ready_low", ready_low, 0);
        chk("burst_overflow", 32'(bus.o_overflow), 0);
        chk("burst_fill", 32'(bus.o_fill_level), 0);

        // Overflow under full back-pressure
        bus.i_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            bus.i_din_valid = 1'b1;
            bus.i_din       = 24'h000010 + 24'(i);
            tick();
        end
        bus.i_din_valid = 1'b0;
        chk("ovf_fill",     32'(bus.o_fill_level), 4);
        chk("ovf_ready",    32'(bus.o_ready),      0);
        chk("ovf_flag",     32'(bus.o_overflow),   1);
        chk("ovf_valid",    32'(bus.o_dout_valid), 1);
        collect(5, 1'b0, 300);
        for (int i = 0; i < 5 && i < rx_q.size(); i++) chk("ovf_word", rx_q[i], 24'h000010 + 24'(i + 1));
        chk("ovf_drain_fill", 32'(bus.o_fill_level), 0);
        chk("ovf_sticky",     32'(bus.o_overflow),   1);
        chk("ovf_end_valid",  32'(bus.o_dout_valid), 0);

        // Reset in the middle of a word with two more queued
        bus.i_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.i_din_valid = 1'b1;
            bus.i_din       = 24'h00ABC0 + 24'(i);
            tick();
        end
        bus.i_din_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        chk("mid_fill", 32'(bus.o_fill_level), 2);
        chk("mid_valid", 32'(bus.o_dout_valid), 1);
        do_reset();
        chk("mrst_valid",    32'(bus.o_dout_valid), 0);
        chk("mrst_dout",     32'(bus.o_dout),       0);
        chk("mrst_fill",     32'(bus.o_fill_level), 0);
        chk("mrst_overflow", 32'(bus.o_overflow),   0);
        chk("mrst_ready",    32'(bus.o_ready),      1);
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.o_dout_valid) vcount++;
            tick();
        end
        chk("mrst_silent", vcount, 0);

        // Enable gap at bit 7
        acc = '0;
        bus.i_din_valid = 1'b1;
        bus.i_din       = 24'h123456;
        tick();
        bus.i_din_valid = 1'b0;
        tick();
        for (int b = 0; b < 7; b++) begin
            acc[b] = bus.o_dout;
            tick();
        end
        held = bus.o_dout;
        en   = 1'b0;
        bus.i_din_valid = 1'b1;
        bus.i_din       = 24'hFFFFFF;
        vcount = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.o_dout !== held || !bus.o_dout_valid || bus.o_fill_level != 0) vcount++;
        end
        chk("en_frozen", vcount, 0);
        en = 1'b1;
        bus.i_din_valid = 1'b0;
        for (int b = 7; b < 24; b++) begin
            acc[b] = bus.o_dout;
            tick();
        end
        chk("en_word",      acc, 24'h123456);
        chk("en_end_valid", 32'(bus.o_dout_valid), 0);
        chk("en_end_fill",  32'(bus.o_fill_level), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
